// File: rtl/led_pkg.sv
// Shared definitions for the LED mode scheduler: FSM state encoding,
// default timing constants and width helpers.
package led_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } led_state_e;

    localparam int DEF_N_MODES      = 4;
    localparam int DEF_DEBOUNCE_CYC = 6;
    localparam int DEF_BLANK_CYC    = 30;
    localparam int DEF_DWELL_CYC    = 3000;

    // Width of a mode index; never collapses to zero bits.
    function automatic int mode_w(input int n_modes);
        return (n_modes <= 2) ? 1 : $clog2(n_modes);
    endfunction

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-FF synchronizer, level debouncer and a
// one-cycle press pulse on each accepted 0->1 change.
module btn_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = cnt_w(DEBOUNCE_CYC);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d;

    // Synchronizer shift and debounce counter next-state.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        if (sync_q[1] == lvl_q) begin
            // Any agreeing sample breaks the run of differing samples.
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            cnt_d   = '0;
            lvl_d   = sync_q[1];
            press_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers, cleared by the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
        end
    end

    assign level = lvl_q;
    assign press = press_q;

endmodule

// File: rtl/led_mode_scheduler.sv
// LED mode scheduler: picks which mode driver owns the board LED, steps
// through modes on debounced next/prev presses, blanks the LED for a
// while on each switch and holds unselected drivers in reset.
// Optional feature macro: LED_AUTO_CYCLE_EN adds a dwell timer that
// issues an internal 'next' after DWELL_CYC cycles in RUN.
module led_mode_scheduler
    import led_pkg::*;
#(
    parameter int N_MODES      = DEF_N_MODES,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int BLANK_CYC    = DEF_BLANK_CYC,
    parameter int DWELL_CYC    = DEF_DWELL_CYC,
    localparam int MW          = mode_w(N_MODES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic [N_MODES-1:0] mode_led_in,
    output logic               led_out,
    output logic [MW-1:0]      mode_sel,
    output logic [N_MODES-1:0] mode_rst,
    output logic               busy
);

    localparam int          BW       = cnt_w(BLANK_CYC);
    localparam logic [MW-1:0] LAST_MODE = MW'(N_MODES - 1);

    led_state_e    state_q, state_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic [MW-1:0] mode_sel_q, mode_sel_d;
    logic          led_q, led_d;

    logic          next_lvl, prev_lvl;
    logic          next_p, prev_p;
    logic          btn_ev;
    logic          dwell_ev;
    logic          ev;
    logic          go_next;
    logic [MW-1:0] mode_inc, mode_dec;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_next),
        .level   (next_lvl),
        .press   (next_p)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_prev (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_prev),
        .level   (prev_lvl),
        .press   (prev_p)
    );

`ifdef LED_AUTO_CYCLE_EN
    localparam int DW = cnt_w(DWELL_CYC);

    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;

    // Dwell timer: counts RUN cycles, clears on every switch and in BLANK.
    always_comb begin
        dwell_ev    = (state_q == ST_RUN) && (dwell_cnt_q == DW'(DWELL_CYC - 1));
        dwell_cnt_d = '0;
        if (state_q == ST_RUN && !ev && !dwell_ev)
            dwell_cnt_d = dwell_cnt_q + DW'(1);
    end

    // Dwell counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dwell_cnt_q <= '0;
        else     dwell_cnt_q <= dwell_cnt_d;
    end
`else
    assign dwell_ev = 1'b0;
`endif

    // Event resolution. Simultaneous next+prev cancel; any button pulse
    // suppresses a coincident dwell event so the user always wins.
    always_comb begin
        btn_ev   = next_p ^ prev_p;
        ev       = btn_ev | (dwell_ev & ~next_p & ~prev_p);
        go_next  = btn_ev ? next_p : 1'b1;
        mode_inc = (mode_sel_q == LAST_MODE) ? '0 : mode_sel_q + MW'(1);
        mode_dec = (mode_sel_q == '0) ? LAST_MODE : mode_sel_q - MW'(1);
    end

    // FSM next-state: RUN forwards the selected LED, BLANK holds it dark.
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        mode_sel_d  = mode_sel_q;
        led_d       = 1'b0;
        case (state_q)
            ST_RUN: begin
                led_d = mode_led_in[mode_sel_q];
                if (ev) begin
                    state_d     = ST_BLANK;
                    mode_sel_d  = go_next ? mode_inc : mode_dec;
                    blank_cnt_d = '0;
                    led_d       = 1'b0;
                end
            end
            ST_BLANK: begin
                // Events seen here are dropped, not queued.
                if (blank_cnt_q == BW'(BLANK_CYC - 1)) begin
                    state_d     = ST_RUN;
                    blank_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d     = ST_BLANK;
                blank_cnt_d = '0;
            end
        endcase
    end

    // FSM and output registers; reset restarts a blank at mode 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BLANK;
            blank_cnt_q <= '0;
            mode_sel_q  <= '0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            mode_sel_q  <= mode_sel_d;
            led_q       <= led_d;
        end
    end

    // Driver resets: only the selected driver runs, and only in RUN.
    always_comb begin
        mode_rst = '1;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < N_MODES; i++)
                mode_rst[i] = (mode_sel_q != MW'(i));
        end
    end

    assign led_out  = led_q;
    assign mode_sel = mode_sel_q;
    assign busy     = (state_q == ST_BLANK);

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Scoreboard bench for led_mode_scheduler (N_MODES=3, DEBOUNCE_CYC=4,
// BLANK_CYC=3, DWELL_CYC=20). Stimulus pushes the mode expected after each
// switch; a negedge monitor pops it when busy rises and checks blanking,
// driver resets and LED forwarding continuously. Build with
// LED_AUTO_CYCLE_EN to exercise the dwell timer instead of button tests.
module tb_led_mode_scheduler;

    localparam int N_MODES = 3;
    localparam int DEB     = 4;
    localparam int BLANK   = 3;
    localparam int DWELL   = 20;

    logic         clk;
    logic         rst;
    logic         btn_next;
    logic         btn_prev;
    logic [2:0]   mode_led_in;
    logic         led_out;
    logic [1:0]   mode_sel;
    logic [2:0]   mode_rst;
    logic         busy;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [1:0]   exp_q[$];

    led_mode_scheduler #(
        .N_MODES      (N_MODES),
        .DEBOUNCE_CYC (DEB),
        .BLANK_CYC    (BLANK),
        .DWELL_CYC    (DWELL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .mode_led_in (mode_led_in),
        .led_out     (led_out),
        .mode_sel    (mode_sel),
        .mode_rst    (mode_rst),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drive raw buttons for 'hold' cycles, starting just after a posedge.
    task automatic press(input bit nx, input bit pv, input int hold);
        @(posedge clk); #1;
        btn_next = nx;
        btn_prev = pv;
        repeat (hold) @(posedge clk);
        #1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait until every expected switch has happened and the FSM is back in RUN.
    task automatic wait_done(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_in_time", 32'(n < limit), 32'd1);
    endtask

    // Mode driver LEDs change randomly every cycle, just after the edge.
    initial begin
        mode_led_in = 3'b000;
        forever begin
            @(posedge clk); #1;
            mode_led_in = 3'($urandom_range(0, 7));
        end
    end

    // Monitor: switch scoreboard, blank length, driver resets, LED latency.
    initial begin
        bit         prev_busy = 1'b1;
        bit         prev_run  = 1'b0;
        bit         prev_in   = 1'b0;
        int         blank_len = 0;
        int         run_len   = 0;
        logic [1:0] e;
        logic [2:0] exp_rst;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b1;
                prev_run  = 1'b0;
                blank_len = 0;
                run_len   = 0;
            end else begin
                if (busy && !prev_busy) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_switch: mode_sel=%0d, required no switch", mode_sel);
                    end else begin
                        e = exp_q.pop_front();
                        check("switch_mode_sel", 32'(mode_sel), 32'(e));
                    end
`ifdef LED_AUTO_CYCLE_EN
                    check("dwell_run_len", run_len, DWELL);
`endif
                end
                if (busy) begin
                    check("blank_led_off", 32'(led_out), 32'd0);
                    check("blank_mode_rst", 32'(mode_rst), 32'h7);
                    blank_len++;
                    prev_run = 1'b0;
                end else begin
                    if (prev_busy) begin
                        check("blank_len", blank_len, BLANK);
                        blank_len = 0;
                        run_len   = 0;
                    end
                    check("mode_sel_range", 32'(mode_sel < 2'd3), 32'd1);
                    exp_rst = 3'b111;
                    if (mode_sel < 2'd3) exp_rst[mode_sel] = 1'b0;
                    check("run_mode_rst", 32'(mode_rst), 32'(exp_rst));
                    if (prev_run) check("led_track", 32'(led_out), 32'(prev_in));
                    prev_in  = (mode_sel < 2'd3) ? mode_led_in[mode_sel] : 1'b0;
                    prev_run = 1'b1;
                    run_len++;
                end
                prev_busy = busy;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int n;
        rst      = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd1);
            check("rst_mode_sel", 32'(mode_sel), 32'd0);
            check("rst_mode_rst", 32'(mode_rst), 32'h7);
            check("rst_led_out", 32'(led_out), 32'd0);
        end

        // Release: three blank cycles, then RUN on mode 0.
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("boot_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("boot_run_busy", 32'(busy), 32'd0);
        check("boot_mode_sel", 32'(mode_sel), 32'd0);
        check("boot_mode_rst", 32'(mode_rst), 32'h6);

`ifdef LED_AUTO_CYCLE_EN
        // Idle: dwell switches 0->1->2->0, 20 RUN cycles apart.
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        wait_done(200);
        check("auto_wrap_mode", 32'(mode_sel), 32'd0);
        // Now at first RUN cycle; a prev press timed to land on the dwell
        // cycle must win, giving one switch to mode 2 instead of 1.
        exp_q.push_back(2'd2);
        repeat (13) @(posedge clk);
        #1;
        btn_prev = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        btn_prev = 1'b0;
        wait_done(60);
        check("auto_btn_wins", 32'(mode_sel), 32'd2);
        idle(4);
`else
        idle(6);
        // Short 3-cycle pulse: rejected by the debouncer.
        press(1'b1, 1'b0, 3);
        idle(12);
        check("short_pulse_no_switch", 32'(mode_sel), 32'd0);

        // 6-cycle hold: exactly one switch.
        exp_q.push_back(2'd1);
        press(1'b1, 1'b0, 6);
        wait_done(60);
        idle(10);
        check("hold_one_switch", 32'(mode_sel), 32'd1);

        // Wraps both directions.
        exp_q.push_back(2'd2);
        press(1'b1, 1'b0, 6);
        wait_done(60);
        idle(10);
        exp_q.push_back(2'd0);
        press(1'b1, 1'b0, 6);
        wait_done(60);
        idle(10);
        check("next_wrap", 32'(mode_sel), 32'd0);
        exp_q.push_back(2'd2);
        press(1'b0, 1'b1, 6);
        wait_done(60);
        idle(10);
        check("prev_wrap", 32'(mode_sel), 32'd2);

        // Both buttons accepted together: cancel.
        press(1'b1, 1'b1, 6);
        idle(14);
        check("both_cancel", 32'(mode_sel), 32'd2);

        // prev accepted two cycles after next, while blanking: dropped.
        exp_q.push_back(2'd0);
        @(posedge clk); #1;
        btn_next = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btn_prev = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        btn_next = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        btn_prev = 1'b0;
        wait_done(60);
        idle(12);
        check("blank_event_dropped", 32'(mode_sel), 32'd0);

        // Reset during a switch toward mode 2.
        exp_q.push_back(2'd1);
        press(1'b1, 1'b0, 6);
        wait_done(60);
        idle(10);
        exp_q.push_back(2'd2);
        press(1'b1, 1'b0, 6);
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("busy_seen_before_rst", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_mode_sel", 32'(mode_sel), 32'd0);
        check("midrst_mode_rst", 32'(mode_rst), 32'h7);
        check("midrst_led_out", 32'(led_out), 32'd0);
        idle(2);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done(40);
        check("post_rst_mode_sel", 32'(mode_sel), 32'd0);
        check("post_rst_mode_rst", 32'(mode_rst), 32'h6);
        idle(6);
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
